// File: rtl/ula_pkg.sv
// Shared types for the ALU sequencer: default widths, the captured ALU
// result record and the sequencer state encoding.
package ula_pkg;

  localparam int ULA_WIDTH = 6;
  localparam int ULA_SEL_W = 4;

  typedef struct packed {
    logic [ULA_WIDTH-1:0] O;
    logic                 Overflow;
    logic                 Zero;
  } ula_res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EMIT  = 2'd2
  } ula_seq_state_t;

endpackage

// File: rtl/ula_res_buf.sv
// Result buffer: one ula_res_t entry per swept Sel value. Written by the
// sweep counter, read combinationally by the emit side. Storage is not reset;
// every entry is rewritten before it is read in a sweep.
module ula_res_buf
  import ula_pkg::*;
#(
  parameter int NUM_OPS = 8,
  parameter int AW      = $clog2(NUM_OPS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  ula_res_t      i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output ula_res_t      o_rd_data
);

  ula_res_t r_mem [NUM_OPS];

  // Capture one ALU result per DRIVE cycle
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ula_sequenciador.sv
// Sequential driver for the combinational arithmetic ALU. Accepts an operand
// pair, sweeps Sel 0..NUM_OPS-1 (one op per cycle, each result sampled after
// a full cycle of settle), buffers the results and streams them out over a
// valid/ready handshake with data held stable while stalled.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int WIDTH   = ULA_WIDTH,
  parameter int SEL_W   = ULA_SEL_W,
  parameter int NUM_OPS = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [SEL_W-1:0] ALU_Sel,
  output logic             ALU_Reset,
  input  logic [WIDTH-1:0] ALU_O,
  input  logic             ALU_Overflow,
  input  logic             ALU_Zero,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [SEL_W-1:0] Out_sel,
  output logic [WIDTH-1:0] Out_O,
  output logic             Out_Overflow,
  output logic             Out_Zero,
  output logic             Out_last,
  output logic             Any_overflow
);

  localparam int               CNT_W    = $clog2(NUM_OPS + 1);
  localparam int               AW       = $clog2(NUM_OPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

  ula_seq_state_t   r_state;
  ula_seq_state_t   w_next;
  logic [CNT_W-1:0] r_sel;
  logic [CNT_W-1:0] r_idx;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_any_ovf;
  ula_res_t         r_out;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_accept;
  logic             w_drive_last;
  logic             w_emit_hs;
  logic             w_emit_last;
  logic             w_buf_we;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  ula_res_t         w_wr_data;
  ula_res_t         w_rd_data;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, handshake strobes and handshake outputs
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_drive_last = 1'b0;
    w_emit_hs    = 1'b0;
    w_emit_last  = (r_idx == LAST_IDX);
    In_ready     = 1'b0;
    Out_valid    = 1'b0;
    Out_last     = 1'b0;
    case (r_state)
      IDLE: begin
        In_ready = 1'b1;
        if (In_valid) begin
          w_accept = 1'b1;
          w_next   = DRIVE;
        end
      end
      DRIVE: begin
        if (r_sel == LAST_IDX) begin
          w_drive_last = 1'b1;
          w_next       = EMIT;
        end
      end
      EMIT: begin
        Out_valid = 1'b1;
        Out_last  = w_emit_last;
        w_emit_hs = Out_ready;
        if (Out_ready && w_emit_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, sweep counter and overflow accumulator; operands and Sel
  // hold outside DRIVE so the ALU does not toggle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_sel     <= '0;
      r_any_ovf <= 1'b0;
    end else if (w_accept) begin
      r_alu_a   <= In_A;
      r_alu_b   <= In_B;
      r_sel     <= '0;
      r_any_ovf <= 1'b0;
    end else if (r_state == DRIVE) begin
      r_any_ovf <= r_any_ovf | ALU_Overflow;
      if (!w_drive_last) begin
        r_sel <= r_sel + 1'b1;
      end
    end
  end

  // Emit index and registered output beat; the next entry is preloaded on
  // each handshake so Out_* only change when the consumer takes a beat
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx     <= '0;
      r_out     <= '0;
      r_out_sel <= '0;
    end else if (w_drive_last) begin
      r_idx     <= '0;
      r_out     <= w_rd_data;
      r_out_sel <= '0;
    end else if (w_emit_hs && !w_emit_last) begin
      r_idx     <= r_idx + 1'b1;
      r_out     <= w_rd_data;
      r_out_sel <= SEL_W'(r_idx + 1'b1);
    end
  end

  // Entry 0 is read while leaving DRIVE; during EMIT the following entry is
  // read so it is ready at the handshake edge
  assign w_rd_addr = (r_state == DRIVE) ? '0 : AW'(r_idx + 1'b1);
  assign w_wr_addr = AW'(r_sel);
  assign w_buf_we  = (r_state == DRIVE);
  assign w_wr_data = '{O: ALU_O, Overflow: ALU_Overflow, Zero: ALU_Zero};

  ula_res_buf #(
    .NUM_OPS (NUM_OPS),
    .AW      (AW)
  ) u_res_buf (
    .i_clk     (Clk),
    .i_we      (w_buf_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign ALU_A        = r_alu_a;
  assign ALU_B        = r_alu_b;
  assign ALU_Sel      = SEL_W'(r_sel);
  assign ALU_Reset    = 1'b0;
  assign Out_sel      = r_out_sel;
  assign Out_O        = r_out.O;
  assign Out_Overflow = r_out.Overflow;
  assign Out_Zero     = r_out.Zero;
  assign Any_overflow = r_any_ovf;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador with a combinational ALU stub
// (O = A + Sel mod 64, Zero = (O==0), Overflow = Sel[0] unless disabled).
module tb_ula_sequenciador;

  typedef struct {
    logic [3:0] sel;
    logic [5:0] o;
    logic       ovf;
    logic       z;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_valid2, out_ready, ovf_en;
  logic [5:0] in_a, in_b;

  // NUM_OPS = 8 instance
  logic       in_ready0, o_valid0, o_last0, any0, alu_rst0, alu_ovf0, alu_z0, o_ovf0, o_z0;
  logic [5:0] alu_a0, alu_b0, alu_o0, o_o0;
  logic [3:0] alu_sel0, o_sel0;
  // NUM_OPS = 2 instance
  logic       in_ready2, o_valid2, o_last2, any2, alu_rst2, alu_ovf2, alu_z2, o_ovf2, o_z2;
  logic [5:0] alu_a2, alu_b2, alu_o2, o_o2;
  logic [3:0] alu_sel2, o_sel2;

  assign alu_o0   = alu_a0 + {2'b00, alu_sel0};
  assign alu_z0   = (alu_o0 == 6'd0);
  assign alu_ovf0 = ovf_en & alu_sel0[0];
  assign alu_o2   = alu_a2 + {2'b00, alu_sel2};
  assign alu_z2   = (alu_o2 == 6'd0);
  assign alu_ovf2 = ovf_en & alu_sel2[0];

  ula_sequenciador #(.WIDTH(6), .SEL_W(4), .NUM_OPS(8)) dut (
    .Clk(clk), .Reset_n(rst_n), .In_valid(in_valid), .In_ready(in_ready0),
    .In_A(in_a), .In_B(in_b), .ALU_A(alu_a0), .ALU_B(alu_b0), .ALU_Sel(alu_sel0),
    .ALU_Reset(alu_rst0), .ALU_O(alu_o0), .ALU_Overflow(alu_ovf0), .ALU_Zero(alu_z0),
    .Out_valid(o_valid0), .Out_ready(out_ready), .Out_sel(o_sel0), .Out_O(o_o0),
    .Out_Overflow(o_ovf0), .Out_Zero(o_z0), .Out_last(o_last0), .Any_overflow(any0)
  );

  ula_sequenciador #(.WIDTH(6), .SEL_W(4), .NUM_OPS(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .In_valid(in_valid2), .In_ready(in_ready2),
    .In_A(in_a), .In_B(in_b), .ALU_A(alu_a2), .ALU_B(alu_b2), .ALU_Sel(alu_sel2),
    .ALU_Reset(alu_rst2), .ALU_O(alu_o2), .ALU_Overflow(alu_ovf2), .ALU_Zero(alu_z2),
    .Out_valid(o_valid2), .Out_ready(out_ready), .Out_sel(o_sel2), .Out_O(o_o2),
    .Out_Overflow(o_ovf2), .Out_Zero(o_z2), .Out_last(o_last2), .Any_overflow(any2)
  );

  exp_t sbq[$];
  int   n_pass = 0, n_total = 0;
  int   cyc = 0, acc_cyc = 0, last_hs_cyc = 0, n_acc = 0, n_recv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void push_sweep(input logic [5:0] a);
    exp_t e;
    for (int s = 0; s < 8; s++) begin
      e.sel  = 4'(s);
      e.o    = a + 6'(s);
      e.ovf  = ovf_en & e.sel[0];
      e.z    = (e.o == 6'd0);
      e.last = (s == 7);
      sbq.push_back(e);
    end
  endfunction

  // One clock of the NUM_OPS=8 instance: score any presented beat, model an
  // accept, then advance past the edge
  task automatic tick();
    exp_t e;
    if (o_valid0) begin
      if (sbq.size() == 0) begin
        check("out_unexpected", 32'(o_valid0), 0);
      end else begin
        e = sbq[0];
        check("out_beat", 32'({o_sel0, o_o0, o_ovf0, o_z0, o_last0}),
              32'({e.sel, e.o, e.ovf, e.z, e.last}));
        if (out_ready) begin
          void'(sbq.pop_front());
          n_recv++;
          if (o_last0) last_hs_cyc = cyc;
        end
      end
    end
    if (in_valid && in_ready0) begin
      push_sweep(in_a);
      acc_cyc = cyc;
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tickr();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_c);
    int g;
    g = 0;
    while (sbq.size() > 0 && g < max_c) begin
      tick();
      g++;
    end
    check("drain_empty", 32'(sbq.size()), 0);
  endtask

  task automatic check_reset();
    check("rst_ctl", 32'({in_ready0, o_valid0, o_last0, any0, alu_rst0}), 32'(5'b10000));
    check("rst_alu", 32'({alu_a0, alu_b0, alu_sel0}), 0);
    check("rst_out", 32'({o_sel0, o_o0, o_ovf0, o_z0}), 0);
  endtask

  initial begin
    int g;
    int stall;
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1; ovf_en = 1'b1;

    // Reset values
    @(posedge clk); #1;
    check_reset();
    check("rst_u2", 32'({in_ready2, o_valid2, o_last2, any2, alu_rst2}), 32'(5'b10000));
    #2 rst_n = 1'b1;
    tickr();

    // Basic sweep A=62 B=5
    in_a = 6'd62; in_b = 6'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("drive_alu", 32'({alu_sel0, alu_a0, alu_b0, o_valid0}),
            32'({4'(k), 6'd62, 6'd5, 1'b0}));
      tick();
    end
    check("first_valid", 32'(o_valid0), 1);
    for (int j = 0; j < 8; j++) begin
      check("busy_emit", 32'({in_ready0, any0}), 32'(2'b01));
      tick();
    end
    check("idle_again", 32'({in_ready0, o_valid0, any0}), 32'(3'b101));
    check("sweep1_q", 32'(sbq.size()), 0);

    // Backpressure A=10: stall 3 cycles at idx 2, random elsewhere
    n_recv = 0; stall = 0; g = 0;
    in_a = 6'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (sbq.size() > 0 && g < 300) begin
      if (o_valid0 && sbq[0].sel == 4'd2 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
        check("stall_hold", 32'({o_sel0, o_o0, o_ovf0, o_z0}), 32'({4'd2, 6'd12, 1'b0, 1'b0}));
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      g++;
    end
    out_ready = 1'b1;
    check("bp_count", 32'(n_recv), 8);
    check("bp_stalls", 32'(stall), 3);
    check("bp_q", 32'(sbq.size()), 0);

    // Overflow-free sweep A=0
    ovf_en = 1'b0;
    in_a = 6'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(40);
    check("noovf_any", 32'(any0), 0);
    ovf_en = 1'b1;

    // Input ignored while busy
    n_acc = 0; g = 0;
    in_a = 6'd20; in_valid = 1'b1;
    while (n_acc < 2 && g < 60) begin
      tick();
      if (n_acc == 1) in_a = 6'd1;
      g++;
    end
    in_valid = 1'b0;
    check("busy_accepts", 32'(n_acc), 2);
    check("second_accept_cyc", 32'(acc_cyc), 32'(last_hs_cyc + 1));
    drain(40);

    // Reset at the 4th DRIVE cycle
    in_a = 6'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_reset();
    sbq.delete();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_drive", 32'({in_ready0, o_valid0}), 32'(2'b10));
      tick();
    end

    // Reset during EMIT at idx 5
    in_a = 6'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!(o_valid0 && sbq.size() > 0 && sbq[0].sel == 4'd5) && g < 40) begin
      tick();
      g++;
    end
    check("reach_idx5", 32'({o_valid0, o_sel0, o_o0}), 32'({1'b1, 4'd5, 6'd8}));
    rst_n = 1'b0;
    #1;
    check_reset();
    sbq.delete();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_emit", 32'({in_ready0, o_valid0}), 32'(2'b10));
      tick();
    end

    // NUM_OPS=2 variant A=63
    in_a = 6'd63; in_valid2 = 1'b1;
    tickr();
    in_valid2 = 1'b0;
    check("n2_c1", 32'({in_ready2, o_valid2}), 0);
    tickr();
    check("n2_c2", 32'(o_valid2), 0);
    tickr();
    check("n2_beat0", 32'({o_valid2, o_sel2, o_o2, o_ovf2, o_z2, o_last2}),
          32'({1'b1, 4'd0, 6'd63, 1'b0, 1'b0, 1'b0}));
    tickr();
    check("n2_beat1", 32'({o_valid2, o_sel2, o_o2, o_ovf2, o_z2, o_last2, any2}),
          32'({1'b1, 4'd1, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1}));
    tickr();
    check("n2_idle", 32'({in_ready2, o_valid2}), 32'(2'b10));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
